// File: rtl/second_tap_serial.sv
// Second-stage biquad IIR section using one time-shared signed multiplier: five MAC cycles,
// then scale/saturate, then output. Build option SECOND_TAP_ROUND_EN adds round-half-up.
module second_tap_serial #(
    parameter int unsigned IW    = 8,
    parameter int unsigned OW    = 10,
    parameter int unsigned CW    = 12,
    parameter int          B0    = 512,
    parameter int          B1    = 963,
    parameter int          B2    = 512,
    parameter int          A1    = 1409,
    parameter int          A2    = 1000,
    parameter int unsigned SHIFT = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [IW-1:0] din,
    input  logic                 din_valid,
    output logic                 busy,
    output logic signed [OW-1:0] dout,
    output logic                 dout_valid,
    output logic                 overrun
);

    localparam int unsigned AW = 32;
    localparam int unsigned PW = CW + OW;

    localparam logic signed [CW-1:0] CoefB0 = CW'(B0);
    localparam logic signed [CW-1:0] CoefB1 = CW'(B1);
    localparam logic signed [CW-1:0] CoefB2 = CW'(B2);
    localparam logic signed [CW-1:0] CoefA1 = CW'(A1);
    localparam logic signed [CW-1:0] CoefA2 = CW'(A2);

    localparam int                   SatMaxI = (1 << (OW - 1)) - 1;
    localparam logic signed [AW-1:0] SatMax  = AW'(SatMaxI);
    localparam logic signed [AW-1:0] SatMin  = AW'(-SatMaxI - 1);
    localparam logic signed [OW-1:0] OutMax  = {1'b0, {(OW - 1){1'b1}}};
    localparam logic signed [OW-1:0] OutMin  = {1'b1, {(OW - 1){1'b0}}};

    typedef enum logic [2:0] {
        StIdle,
        StMac0,
        StMac1,
        StMac2,
        StMac3,
        StMac4,
        StScale,
        StOut
    } state_e;

    state_e state_q, state_d;

    logic signed [IW-1:0] x0_q, x1_q, x2_q;
    logic signed [OW-1:0] y1_q, y2_q;
    logic signed [AW-1:0] acc_q, acc_d;
    logic signed [OW-1:0] res_q, res_d;
    logic signed [OW-1:0] dout_q;
    logic                 dout_valid_q;
    logic                 overrun_q;

    logic                 accept;
    logic                 mac_en;
    logic                 mac_sub;
    logic                 scale_en;
    logic                 out_en;
    logic signed [CW-1:0] coef_sel;
    logic signed [OW-1:0] data_sel;
    logic signed [PW-1:0] prod;
    logic signed [AW-1:0] prod_ext;
    logic signed [AW-1:0] acc_adj;
    logic signed [AW-1:0] shifted;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (din_valid) state_d = StMac0;
            StMac0:  state_d = StMac1;
            StMac1:  state_d = StMac2;
            StMac2:  state_d = StMac3;
            StMac3:  state_d = StMac4;
            StMac4:  state_d = StScale;
            StScale: state_d = StOut;
            StOut:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output / datapath control decode
    always_comb begin
        busy     = (state_q != StIdle);
        accept   = 1'b0;
        mac_en   = 1'b0;
        mac_sub  = 1'b0;
        scale_en = 1'b0;
        out_en   = 1'b0;
        coef_sel = '0;
        data_sel = '0;
        unique case (state_q)
            StIdle: accept = din_valid;
            StMac0: begin
                mac_en   = 1'b1;
                coef_sel = CoefB0;
                data_sel = OW'(x0_q);
            end
            StMac1: begin
                mac_en   = 1'b1;
                coef_sel = CoefB1;
                data_sel = OW'(x1_q);
            end
            StMac2: begin
                mac_en   = 1'b1;
                coef_sel = CoefB2;
                data_sel = OW'(x2_q);
            end
            StMac3: begin
                mac_en   = 1'b1;
                coef_sel = CoefA1;
                data_sel = y1_q;
            end
            StMac4: begin
                mac_en   = 1'b1;
                mac_sub  = 1'b1;
                coef_sel = CoefA2;
                data_sel = y2_q;
            end
            StScale: scale_en = 1'b1;
            StOut:   out_en   = 1'b1;
            default: ;
        endcase
    end

    // Shared multiplier; operands sign-extended to the full product width first
    always_comb begin
        prod     = PW'(coef_sel) * PW'(data_sel);
        prod_ext = AW'(prod);
        acc_d    = mac_sub ? (acc_q - prod_ext) : (acc_q + prod_ext);
    end

`ifdef SECOND_TAP_ROUND_EN
    localparam logic signed [AW-1:0] Rnd = AW'(1) << (SHIFT - 1);
    assign acc_adj = acc_q + Rnd;
`else
    assign acc_adj = acc_q;
`endif

    always_comb begin
        shifted = acc_adj >>> SHIFT;
        if (shifted > SatMax) begin
            res_d = OutMax;
        end else if (shifted < SatMin) begin
            res_d = OutMin;
        end else begin
            res_d = shifted[OW-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x0_q         <= '0;
            x1_q         <= '0;
            x2_q         <= '0;
            y1_q         <= '0;
            y2_q         <= '0;
            acc_q        <= '0;
            res_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            if (accept) begin
                x0_q  <= din;
                acc_q <= '0;
            end
            if (mac_en) begin
                acc_q <= acc_d;
            end
            if (scale_en) begin
                res_q <= res_d;
            end
            if (out_en) begin
                dout_q <= res_q;
                x2_q   <= x1_q;
                x1_q   <= x0_q;
                y2_q   <= y1_q;
                y1_q   <= res_q;
            end
            dout_valid_q <= out_en;
            // A strobe while busy (OUT cycle included) is dropped and latched here
            if (din_valid && busy) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_second_tap_serial.sv
// Scoreboard bench for second_tap_serial: default instance plus a large-coefficient instance
// for saturation; expected outputs and their due cycles are queued at stimulus time.
module tb_second_tap_serial;

    typedef struct {
        int val;
        int due;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic signed [7:0] din_a, din_b;
    logic              dv_a, dv_b;
    logic              busy_a, busy_b;
    logic signed [9:0] dout_a, dout_b;
    logic              dvo_a, dvo_b;
    logic              ovr_a, ovr_b;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   nval_a = 0;
    int   nval_b = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    int   mx1, mx2, my1, my2;

    second_tap_serial u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .din        (din_a),
        .din_valid  (dv_a),
        .busy       (busy_a),
        .dout       (dout_a),
        .dout_valid (dvo_a),
        .overrun    (ovr_a)
    );

    second_tap_serial #(
        .CW (13),
        .B0 (4095),
        .B1 (4095),
        .B2 (4095)
    ) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .din        (din_b),
        .din_valid  (dv_b),
        .busy       (busy_b),
        .dout       (dout_b),
        .dout_valid (dvo_b),
        .overrun    (ovr_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: pop and compare whenever a DUT strobes dout_valid
    initial forever begin
        @(negedge clk);
        if (dvo_a === 1'b1) begin
            nval_a++;
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_valid: got dout %0d, expected no strobe", dout_a);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                check("a_dout", int'(dout_a), e.val);
                check("a_latency", cyc, e.due);
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (dvo_b === 1'b1) begin
            nval_b++;
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_valid: got dout %0d, expected no strobe", dout_b);
            end else begin
                exp_t e;
                e = q_b.pop_front();
                check("b_dout", int'(dout_b), e.val);
                check("b_latency", cyc, e.due);
            end
        end
    end

    // Called at a negedge; strobes for one cycle and returns at the next negedge
    task automatic send(input bit sel_b, input int v, input bit exp_en, input int exp_v);
        exp_t e;
        e.val = exp_v;
        e.due = cyc + 8;
        if (sel_b) begin
            din_b = 8'(v);
            dv_b  = 1'b1;
            if (exp_en) q_b.push_back(e);
        end else begin
            din_a = 8'(v);
            dv_a  = 1'b1;
            if (exp_en) q_a.push_back(e);
        end
        @(negedge clk);
        dv_a = 1'b0;
        dv_b = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (q_a.size() != 0 || q_b.size() != 0); i++) @(negedge clk);
        if (q_a.size() != 0 || q_b.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d/%0d pending, expected 0", q_a.size(), q_b.size());
            q_a.delete();
            q_b.delete();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        q_a.delete();
        q_b.delete();
        idle(2);
        rst = 1'b0;
        idle(1);
    endtask

    function automatic int model_step(input int x0);
        int acc, y;
        acc = 512 * x0 + 963 * mx1 + 512 * mx2 + 1409 * my1 - 1000 * my2;
`ifdef SECOND_TAP_ROUND_EN
        acc = acc + 1024;
`endif
        y = acc >>> 11;
        if (y > 511) y = 511;
        if (y < -512) y = -512;
        mx2 = mx1;
        mx1 = x0;
        my2 = my1;
        my1 = y;
        return y;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        rst   = 1'b1;
        din_a = '0;
        din_b = '0;
        dv_a  = 1'b0;
        dv_b  = 1'b0;
        idle(3);
        check("rst_dout", int'(dout_a), 0);
        check("rst_dout_valid", int'(dvo_a), 0);
        check("rst_busy", int'(busy_a), 0);
        check("rst_overrun", int'(ovr_a), 0);
        rst = 1'b0;
        idle(1);

        // Impulse
        send(0, 100, 1, 25);
        check("impulse_busy", int'(busy_a), 1);
        idle(7);
        send(0, 0, 1, 64);
        drain();
        idle(3);
        check("hold_dout", int'(dout_a), 64);
        check("idle_busy", int'(busy_a), 0);
        check("impulse_overrun", int'(ovr_a), 0);

        // Rounding
        do_reset();
`ifdef SECOND_TAP_ROUND_EN
        send(0, 3, 1, 1);
`else
        send(0, 3, 1, 0);
`endif
        drain();

        // Saturation on the large-coefficient instance
        do_reset();
`ifdef SECOND_TAP_ROUND_EN
        send(1, 127, 1, 254);
`else
        send(1, 127, 1, 253);
`endif
        idle(7);
        send(1, 127, 1, 511);
        drain();
        do_reset();
        send(1, -128, 1, -256);
        drain();

        // Overrun during MAC
        do_reset();
        n0 = nval_a;
        send(0, 100, 1, 25);
        idle(3);
        send(0, 77, 0, 0);
        check("overrun_set", int'(ovr_a), 1);
        idle(3);
        send(0, 0, 1, 64);
        drain();
        check("overrun_valid_count", nval_a - n0, 2);
        check("overrun_sticky", int'(ovr_a), 1);

        // Strobe in the OUT cycle is dropped; the very next cycle is accepted
        do_reset();
        send(0, 100, 1, 25);
        idle(6);
        send(0, 55, 0, 0);
        send(0, 0, 1, 64);
        drain();
        check("out_cycle_overrun", int'(ovr_a), 1);

        // Async reset during MAC2
        n0 = nval_a;
        send(0, 100, 1, 25);
        idle(2);
        rst = 1'b1;
        q_a.delete();
        #1;
        check("midrst_dout", int'(dout_a), 0);
        check("midrst_dout_valid", int'(dvo_a), 0);
        check("midrst_busy", int'(busy_a), 0);
        check("midrst_overrun", int'(ovr_a), 0);
        @(negedge clk);
        rst = 1'b0;
        idle(12);
        check("midrst_no_valid", nval_a - n0, 0);
        send(0, 100, 1, 25);
        drain();

        // Back-to-back at minimum spacing
        do_reset();
        mx1 = 0;
        mx2 = 0;
        my1 = 0;
        my2 = 0;
        n0  = nval_a;
        for (int i = 0; i < 20; i++) begin
            send(0, 50, 1, model_step(50));
            idle(7);
        end
        drain();
        check("b2b_valid_count", nval_a - n0, 20);
        check("b2b_overrun", int'(ovr_a), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
